// File: rtl/top_level_pkg.sv
// Shared types and constants for the Hamming(16,11) encoder engine.
// Addresses and sizes are fixed at build time; widths are derived from them.
package top_level_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int MSG_W     = 11;
    localparam int CODE_W    = 16;
    localparam int NUM_WORDS = 15;
    localparam int MEM_DEPTH = 256;
    localparam int CNT_W     = $clog2(NUM_WORDS);

    localparam logic [ADDR_W-1:0] SRC_BASE = 8'd0;
    localparam logic [ADDR_W-1:0] DST_BASE = 8'd30;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } state_e;

endpackage

// File: rtl/data_mem.sv
// Byte-wide single-port data memory: combinational read, clocked write.
// Contents are deliberately not reset.
module data_mem
    import top_level_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] Core [0:MEM_DEPTH-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            Core[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = Core[addr_i];

endmodule

// File: rtl/hamming_enc.sv
// Combinational Hamming(16,11) SECDED encoder.
// Output layout: {d11..d5, p8, d4, d3, d2, p4, d1, p2, p1, p0}.
module hamming_enc
    import top_level_pkg::*;
(
    input  logic [MSG_W-1:0]  d_i,
    output logic [CODE_W-1:0] code_o
);

    logic p8, p4, p2, p1, p0;
    logic [CODE_W-2:0] body;

    // d_i[0] is d1, d_i[10] is d11
    assign p8 = ^d_i[10:4];
    assign p4 = ^{d_i[10:7], d_i[3:1]};
    assign p2 = ^{d_i[10], d_i[9], d_i[6], d_i[5], d_i[3], d_i[2], d_i[0]};
    assign p1 = ^{d_i[10], d_i[8], d_i[6], d_i[4], d_i[3], d_i[1], d_i[0]};

    assign body   = {d_i[10:4], p8, d_i[3:1], p4, d_i[0], p2, p1};
    assign p0     = ^body;
    assign code_o = {body, p0};

endmodule

// File: rtl/top_level.sv
// Encoder engine: on Start's falling edge, encodes NUM_WORDS packed messages
// from SRC_BASE into codewords at DST_BASE, then raises Ack.
module top_level
    import top_level_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic Start,
    output logic Ack
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        lo_q, lo_d;
    logic [2:0]        hi_q, hi_d;
    logic              ack_q;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] word_offs;
    logic [CODE_W-1:0] code;

    assign word_offs = {{(ADDR_W-CNT_W-1){1'b0}}, cnt_q, 1'b0};

    hamming_enc u_enc (
        .d_i    ({hi_q, lo_q}),
        .code_o (code)
    );

    // Writes are suppressed while Reset is held so a reset landing in a
    // write state cannot corrupt memory.
    data_mem DM1 (
        .clk_i   (Clk),
        .we_i    (mem_we & ~Reset),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        mem_we    = 1'b0;
        mem_addr  = SRC_BASE + word_offs;
        mem_wdata = code[7:0];
        case (state_q)
            IDLE:  if (Start) state_d = ARMED;
            ARMED: begin
                if (!Start) begin
                    state_d = RD_LO;
                    cnt_d   = '0;
                end
            end
            RD_LO: begin
                lo_d    = mem_rdata;
                state_d = RD_HI;
            end
            RD_HI: begin
                mem_addr = SRC_BASE + word_offs + 8'd1;
                hi_d     = mem_rdata[2:0];
                state_d  = WR_LO;
            end
            WR_LO: begin
                mem_addr  = DST_BASE + word_offs;
                mem_we    = 1'b1;
                mem_wdata = code[7:0];
                state_d   = WR_HI;
            end
            WR_HI: begin
                mem_addr  = DST_BASE + word_offs + 8'd1;
                mem_we    = 1'b1;
                mem_wdata = code[15:8];
                if (cnt_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = RD_LO;
                end
            end
            DONE:  if (Start) state_d = ARMED;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            ack_q   <= (state_d == DONE);
        end
    end

    assign Ack = ack_q;

endmodule

// File: tb/tb_top_level.sv
// Scoreboard bench for the Hamming encoder engine: expected memory writes are
// queued at stimulus time and matched by a write-port monitor.
module tb_top_level;
    import top_level_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic ack;

    always #5 clk = ~clk;

    top_level dut (
        .Clk   (clk),
        .Reset (reset),
        .Start (start),
        .Ack   (ack)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t exp_q[$];

    // Hand-computed vectors: source bytes and expected codeword bytes.
    logic [7:0] v_lo [15] = '{8'h4E, 8'h1C, 8'hBA, 8'h00, 8'hFF, 8'h1C, 8'h01, 8'h00,
                              8'h4E, 8'hFF, 8'hBA, 8'h01, 8'h00, 8'h00, 8'h4E};
    logic [7:0] v_hi [15] = '{8'h00, 8'h04, 8'h06, 8'h00, 8'h07, 8'hFC, 8'h00, 8'h04,
                              8'hF8, 8'hFF, 8'hA6, 8'hF8, 8'h04, 8'hF8, 8'h00};
    logic [7:0] e_lo [15] = '{8'hF6, 8'hD7, 8'hB1, 8'h00, 8'hFF, 8'hD7, 8'h0F, 8'h17,
                              8'hF6, 8'hFF, 8'hB1, 8'h0F, 8'h17, 8'h00, 8'hF6};
    logic [7:0] e_hi [15] = '{8'h09, 8'h82, 8'hD7, 8'h00, 8'hFF, 8'h82, 8'h00, 8'h81,
                              8'h09, 8'hFF, 8'hD7, 8'h00, 8'h81, 8'h00, 8'h09};

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_run(input int nwords);
        wr_t w;
        for (int k = 0; k < nwords; k++) begin
            w.addr = 8'(30 + 2*k);     w.data = e_lo[k]; exp_q.push_back(w);
            w.addr = 8'(30 + 2*k + 1); w.data = e_hi[k]; exp_q.push_back(w);
        end
    endtask

    task automatic fill_dst(input logic [7:0] val);
        for (int a = 30; a < 60; a++) dut.DM1.Core[a] <= val;
    endtask

    task automatic load_src();
        for (int k = 0; k < 15; k++) begin
            dut.DM1.Core[2*k]   <= v_lo[k];
            dut.DM1.Core[2*k+1] <= v_hi[k];
        end
    endtask

    task automatic wait_ack(output int lat);
        lat = 0;
        while (ack !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_dst(input string tag);
        for (int k = 0; k < 15; k++) begin
            check8($sformatf("%s_dst[%0d]", tag, 30 + 2*k),     dut.DM1.Core[30 + 2*k],     e_lo[k]);
            check8($sformatf("%s_dst[%0d]", tag, 30 + 2*k + 1), dut.DM1.Core[30 + 2*k + 1], e_hi[k]);
        end
    endtask

    // Monitor: every write the DUT presents must match the next queued expectation.
    always @(negedge clk) begin
        wr_t e;
        if (dut.DM1.we_i === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %h data %h with nothing expected",
                         dut.DM1.addr_i, dut.DM1.wdata_i);
            end else begin
                e = exp_q.pop_front();
                if (dut.DM1.addr_i !== e.addr || dut.DM1.wdata_i !== e.data) begin
                    errors++;
                    $display("FAIL mem_write: got addr %h data %h expected addr %h data %h",
                             dut.DM1.addr_i, dut.DM1.wdata_i, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        int lat;
        int bad;

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check8("reset_ack", {7'd0, ack}, 8'h00);
        check8("reset_state", 8'(dut.state_q), 8'(IDLE));

        // Start never pulsed: nothing may happen.
        fill_dst(8'h5A);
        dut.DM1.Core[60] <= 8'hA5;
        bad = 0;
        repeat (80) begin
            @(negedge clk);
            if (ack !== 1'b0) bad++;
        end
        check8("idle_ack_low", 8'(bad), 8'h00);
        check8("idle_state", 8'(dut.state_q), 8'(IDLE));
        check8("idle_dst30", dut.DM1.Core[30], 8'h5A);

        // Full run; source is loaded while Start is high.
        start = 1'b1;
        @(negedge clk);
        load_src();
        repeat (3) @(negedge clk);
        check8("armed_state", 8'(dut.state_q), 8'(ARMED));
        push_run(15);
        start = 1'b0;
        @(posedge clk);
        #1;
        check8("run_entry", 8'(dut.state_q), 8'(RD_LO));
        wait_ack(lat);
        check8("ack_latency", 8'(lat), 8'd60);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack !== 1'b1) bad++;
        end
        check8("ack_held", 8'(bad), 8'h00);
        check_dst("run1");
        for (int k = 0; k < 15; k++) begin
            check8($sformatf("src_lo[%0d]", 2*k),   dut.DM1.Core[2*k],   v_lo[k]);
            check8($sformatf("src_hi[%0d]", 2*k+1), dut.DM1.Core[2*k+1], v_hi[k]);
        end
        check8("mem60_untouched", dut.DM1.Core[60], 8'hA5);
        check8("queue_empty_run1", 8'(exp_q.size()), 8'h00);

        // From DONE, Start relaunches; reset after 5 words aborts the run.
        fill_dst(8'h5A);
        start = 1'b1;
        @(posedge clk);
        #1;
        check8("ack_drop_on_start", {7'd0, ack}, 8'h00);
        repeat (2) @(negedge clk);
        push_run(5);
        start = 1'b0;
        @(posedge clk);
        #1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check8("midrun_ack", {7'd0, ack}, 8'h00);
        check8("midrun_state", 8'(dut.state_q), 8'(IDLE));
        @(negedge clk);
        reset = 1'b0;
        check8("midrun_word4_lo", dut.DM1.Core[38], e_lo[4]);
        check8("midrun_word4_hi", dut.DM1.Core[39], e_hi[4]);
        check8("midrun_word5_unwritten", dut.DM1.Core[40], 8'h5A);
        check8("queue_empty_midrun", 8'(exp_q.size()), 8'h00);

        // Rerun from word 0 after the aborted run.
        start = 1'b1;
        repeat (2) @(negedge clk);
        push_run(15);
        start = 1'b0;
        @(posedge clk);
        #1;
        wait_ack(lat);
        check8("rerun_latency", 8'(lat), 8'd60);
        check_dst("run2");
        check8("queue_empty_run2", 8'(exp_q.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
